// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MIPS MEM-stage port.
// Word loads/stores and byte stores against a local RAM, plus a small MMIO
// window holding a byte-wide debug FIFO, a free-running cycle counter and a
// saturating drop counter. Loads are combinational; all state commits at the
// rising edge, so the core never stalls.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        sb,
  output logic [31:0] readdata,
  output logic        dbg_valid,
  output logic [7:0]  dbg_data,
  input  logic        dbg_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [FW:0]   FULL_CNT = FIFO_DEPTH[FW:0];
  localparam logic [FW:0]   CNT_ONE  = 1;
  localparam logic [FW-1:0] PTR_ONE  = 1;

  localparam logic [7:0] OFS_FIFO  = 8'h00;
  localparam logic [7:0] OFS_CYCLE = 8'h04;
  localparam logic [7:0] OFS_DROP  = 8'h08;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          is_mmio;
  logic [7:0]    mmio_ofs;
  logic [AW-1:0] word_idx;

  assign is_mmio  = (addr[31:8] == 24'hFFFFFF);
  assign mmio_ofs = addr[7:0];
  assign word_idx = addr[AW+1:2];

  // ---------------------------------------------------------------------------
  // RAM (contents deliberately not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [DEPTH_WORDS];
  logic [31:0] ram_wdata_d;
  logic [3:0]  byte_en;
  logic        ram_we;

  assign ram_we  = memwrite & ~is_mmio;
  assign byte_en = sb ? (4'b0001 << addr[1:0]) : 4'b1111;

  // Merge the store into the currently addressed word; unselected lanes keep old data.
  always_comb begin
    ram_wdata_d = ram_q[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        ram_wdata_d[8*i +: 8] = sb ? writedata[7:0] : writedata[8*i +: 8];
      end
    end
  end

  // Commit the merged word at the edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[word_idx] <= ram_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW:0]   count_q,  count_d;
  logic          fifo_full, fifo_empty;
  logic          push_req, push_ok, pop, drop;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign dbg_valid  = ~fifo_empty;
  assign dbg_data   = fifo_mem[rd_ptr_q];

  assign push_req = memwrite & is_mmio & (mmio_ofs == OFS_FIFO);
  assign pop      = dbg_valid & dbg_ready;
  // When full, a same-cycle pop frees the head slot, so the push still lands.
  assign push_ok  = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;

  // Next pointers and occupancy from push/pop; pointers wrap by width.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO control state; cleared asynchronously so dbg_valid drops at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage is not reset; the head is only meaningful while dbg_valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= writedata[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_q, cycle_d;
  logic [15:0] dropcnt_q, dropcnt_d;

  // Free-running cycle count and saturating drop count; any write to 0x08 clears drops.
  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    dropcnt_d = dropcnt_q;
    if (memwrite && is_mmio && (mmio_ofs == OFS_DROP)) begin
      dropcnt_d = 16'd0;
    end else if (drop && (dropcnt_q != 16'hFFFF)) begin
      dropcnt_d = dropcnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      dropcnt_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      dropcnt_q <= dropcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: zero latency, pre-edge state
  // ---------------------------------------------------------------------------
  // Select RAM word or MMIO register for the current address.
  always_comb begin
    readdata = '0;
    if (is_mmio) begin
      case (mmio_ofs)
        OFS_FIFO:  readdata = {30'b0, fifo_full, fifo_empty};
        OFS_CYCLE: readdata = cycle_q;
        OFS_DROP:  readdata = {16'b0, dropcnt_q};
        default:   readdata = '0;
      endcase
    end else begin
      readdata = ram_q[word_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus a randomized run, all
// checked against a byte-addressed memory / queue-based reference model.
module tb_dmem_responder;

  localparam int DW = 64;
  localparam int FD = 4;
  localparam int BA = $clog2(4 * DW);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic        sb = 1'b0;
  logic [31:0] readdata;
  logic        dbg_valid;
  logic [7:0]  dbg_data;
  logic        dbg_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0]  mbytes [4*DW];
  bit          mwr    [4*DW];
  logic [7:0]  mq [$];
  logic [15:0] mdrop = 16'h0;
  logic [31:0] mcycle = 32'h0;

  dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .sb(sb), .readdata(readdata),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    mq.delete();
    mdrop  = 16'h0;
    mcycle = 32'h0;
  endfunction

  // Expected load value for address a given the model state before the edge.
  function automatic void exp_read(input logic [31:0] a, output bit known, output logic [31:0] v);
    int base;
    known = 1'b1;
    v = 32'h0;
    if (a[31:8] == 24'hFFFFFF) begin
      case (a[7:0])
        8'h00:   v = {30'b0, (mq.size() == FD), (mq.size() == 0)};
        8'h04:   v = mcycle;
        8'h08:   v = {16'b0, mdrop};
        default: v = 32'h0;
      endcase
    end else begin
      base = int'(a[BA-1:0]) & ~3;
      for (int k = 0; k < 4; k++) begin
        if (!mwr[base+k]) known = 1'b0;
        v[8*k +: 8] = mbytes[base+k];
      end
    end
  endfunction

  // Apply current inputs to the model, then advance one clock.
  task automatic tick();
    bit mmio, pop, push, full;
    int b;
    mmio = (addr[31:8] == 24'hFFFFFF);
    pop  = (mq.size() != 0) && dbg_ready;
    push = memwrite && mmio && (addr[7:0] == 8'h00);
    full = (mq.size() == FD);
    if (memwrite && !mmio) begin
      b = int'(addr[BA-1:0]);
      if (sb) begin
        mbytes[b] = writedata[7:0];
        mwr[b] = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          mbytes[(b & ~3) + k] = writedata[8*k +: 8];
          mwr[(b & ~3) + k] = 1'b1;
        end
      end
    end
    if (memwrite && mmio && (addr[7:0] == 8'h08)) mdrop = 16'h0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (!full || pop) mq.push_back(writedata[7:0]);
      else if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
    end
    mcycle = mcycle + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memwrite = 1'b0;
    sb = 1'b0;
    writedata = 32'h0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    addr = 32'hFFFFFF00; #1;
    checks++;
    if (dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dbg_valid); end
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL reset_status: got %h want 00000001", readdata); end
    addr = 32'hFFFFFF08; #1;
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL reset_drop: got %h want 0", readdata); end
    reset = 1'b0;
    model_clear();
    addr = 32'hFFFFFF04; #1;
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL cycle_first: got %h want 0", readdata); end
    tick();
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL cycle_after_edge: got %h want 1", readdata); end
  endtask

  task automatic test_word_byte();
    addr = 32'h10; writedata = 32'h11223344; memwrite = 1'b1; sb = 1'b0;
    tick();
    addr = 32'h12; writedata = 32'h555555AA; sb = 1'b1;
    tick();
    idle_inputs();
    addr = 32'h10; #1;
    checks++;
    if (readdata !== 32'h11AA3344) begin errors++; $display("FAIL sb_merge: got %h want 11aa3344", readdata); end
    addr = 32'h10 + 4 * DW; #1;
    checks++;
    if (readdata !== 32'h11AA3344) begin errors++; $display("FAIL alias: got %h want 11aa3344", readdata); end
  endtask

  task automatic test_rdw();
    addr = 32'h20; writedata = 32'h01020304; memwrite = 1'b1; sb = 1'b0;
    tick();
    writedata = 32'hDEADBEEF; #1;
    checks++;
    if (readdata !== 32'h01020304) begin errors++; $display("FAIL rdw_old: got %h want 01020304", readdata); end
    tick();
    idle_inputs(); #1;
    checks++;
    if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_new: got %h want deadbeef", readdata); end
  endtask

  task automatic test_fifo_fill();
    dbg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr = 32'hFFFFFF00; writedata = 32'h41 + i; memwrite = 1'b1;
      tick();
    end
    idle_inputs();
    addr = 32'hFFFFFF00; #1;
    checks++;
    if (readdata !== 32'h2) begin errors++; $display("FAIL fifo_full_status: got %h want 2", readdata); end
    addr = 32'hFFFFFF08; #1;
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL dropcnt_one: got %h want 1", readdata); end
    dbg_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (dbg_valid !== 1'b1 || dbg_data !== 8'(8'h41 + i))
        begin errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, dbg_valid, dbg_data, 8'(8'h41 + i)); end
      tick();
    end
    addr = 32'hFFFFFF00; #1;
    checks++;
    if (dbg_valid !== 1'b0 || readdata !== 32'h1)
      begin errors++; $display("FAIL drained_empty: got v=%b st=%h want v=0 st=1", dbg_valid, readdata); end
    dbg_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] expect_seq [4];
    expect_seq[0] = 8'h52; expect_seq[1] = 8'h53; expect_seq[2] = 8'h54; expect_seq[3] = 8'h99;
    dbg_ready = 1'b0;
    addr = 32'hFFFFFF08; memwrite = 1'b1; writedata = 32'h0;
    tick();
    for (int i = 0; i < 4; i++) begin
      addr = 32'hFFFFFF00; writedata = 32'h51 + i; memwrite = 1'b1;
      tick();
    end
    dbg_ready = 1'b1; writedata = 32'h99; #1;
    checks++;
    if (readdata !== 32'h2 || dbg_data !== 8'h51)
      begin errors++; $display("FAIL pp_full_head: got st=%h d=%h want st=2 d=51", readdata, dbg_data); end
    tick();
    idle_inputs();
    addr = 32'hFFFFFF08;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (dbg_valid !== 1'b1 || dbg_data !== expect_seq[i] || readdata !== 32'h0)
        begin errors++; $display("FAIL pp_seq_%0d: got v=%b d=%h drop=%h want v=1 d=%h drop=0", i, dbg_valid, dbg_data, readdata, expect_seq[i]); end
      tick();
    end
    dbg_ready = 1'b0;
  endtask

  task automatic test_counters();
    int n;
    #1; reset = 1'b1; #2; reset = 1'b0;
    model_clear();
    n = $urandom_range(5, 40);
    idle_inputs();
    repeat (n) tick();
    addr = 32'hFFFFFF04; #1;
    checks++;
    if (readdata !== 32'(n)) begin errors++; $display("FAIL cycle_n: got %0d want %0d", readdata, n); end
    dbg_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      addr = 32'hFFFFFF00; writedata = $urandom; memwrite = 1'b1;
      tick();
    end
    addr = 32'hFFFFFF08; idle_inputs(); #1;
    checks++;
    if (readdata !== 32'h3) begin errors++; $display("FAIL drop_three: got %h want 3", readdata); end
    memwrite = 1'b1; writedata = $urandom;
    tick();
    idle_inputs(); #1;
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL drop_clear: got %h want 0", readdata); end
    addr = 32'hFFFFFF00; memwrite = 1'b1; writedata = 32'h77;
    repeat (65540) tick();
    idle_inputs();
    addr = 32'hFFFFFF08; #1;
    checks++;
    if (readdata !== 32'hFFFF) begin errors++; $display("FAIL drop_sat: got %h want ffff", readdata); end
    checks++;
    if (readdata !== {16'b0, mdrop}) begin errors++; $display("FAIL drop_sat_model: got %h want %h", readdata, mdrop); end
  endtask

  task automatic test_mid_reset();
    #1; reset = 1'b1; #1; reset = 1'b0;
    model_clear();
    dbg_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 32'hFFFFFF00; writedata = 32'hC0 + i; memwrite = 1'b1;
      tick();
    end
    idle_inputs(); #1;
    checks++;
    if (dbg_valid !== 1'b1 || dbg_data !== 8'hC0)
      begin errors++; $display("FAIL pre_reset_head: got v=%b d=%h want v=1 d=c0", dbg_valid, dbg_data); end
    #1; reset = 1'b1; #1;
    checks++;
    if (dbg_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", dbg_valid); end
    checks++;
    if (readdata !== 32'h1) begin errors++; $display("FAIL async_reset_status: got %h want 1", readdata); end
    addr = 32'h10; #1;
    checks++;
    if (readdata !== 32'h11AA3344) begin errors++; $display("FAIL ram_retained: got %h want 11aa3344", readdata); end
    reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    mcycle = 32'h1;
  endtask

  task automatic test_random();
    bit known;
    logic [31:0] v;
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      if (r < 3) addr = {24'hFFFFFF, 8'($urandom_range(0, 4) * 4)};
      else addr = $urandom & 32'h00FF_FFFF;
      memwrite  = ($urandom_range(0, 9) < 4);
      sb        = $urandom_range(0, 1);
      writedata = $urandom;
      dbg_ready = ($urandom_range(0, 2) == 0);
      #1;
      exp_read(addr, known, v);
      if (known) begin
        checks++;
        if (readdata !== v) begin errors++; $display("FAIL rand_read_%0d: addr=%h got %h want %h", c, addr, readdata, v); end
      end
      checks++;
      if (dbg_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid_%0d: got %b want %b", c, dbg_valid, (mq.size() != 0)); end
      if (mq.size() != 0) begin
        checks++;
        if (dbg_data !== mq[0]) begin errors++; $display("FAIL rand_data_%0d: got %h want %h", c, dbg_data, mq[0]); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 4 * DW; i++) begin
      mbytes[i] = 8'h0;
      mwr[i] = 1'b0;
    end
    test_reset();
    test_word_byte();
    test_rdw();
    test_fifo_fill();
    test_push_pop_full();
    test_counters();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core's MEM-stage port. Services word loads/stores and byte stores (`sb`) against a local RAM, and decodes a small memory-mapped I/O window. The window holds a byte-wide debug output FIFO with a ready/valid drain port, a free-running cycle counter and a drop counter. Sits between the core's data port and the rest of the system; the core never stalls on it.

## Interface
- `DEPTH_WORDS`, 64: RAM size in 32-bit words; power of two, ≥4.
- `FIFO_DEPTH`, 4: debug FIFO entries; power of two, ≥2.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `memwrite` in 1: store strobe from the core (MEM stage).
- `addr` in 32: byte address (the core's ALU result in MEM).
- `writedata` in 32: store data.
- `sb` in 1: with `memwrite`, selects a byte store instead of a word store.
- `readdata` out 32: load data, combinational from `addr`.
- `dbg_valid` out 1: the FIFO head is valid.
- `dbg_data` out 8: the FIFO head byte.
- `dbg_ready` in 1: the consumer accepts the head.

## Operation
- Address decode:
  - MMIO when `addr[31:8]==24'hFFFFFF`; otherwise RAM.
  - RAM word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so accesses alias/wrap.
- RAM loads: `readdata` = the addressed word, combinationally. `addr[1:0]` is ignored for loads.
- RAM word store (`memwrite & ~sb`): writes the full word at the edge.
- RAM byte store (`memwrite & sb`):
  - Writes `writedata[7:0]` into lane `addr[1:0]`; little-endian, lane 0 = bits 7:0.
  - The other lanes are unchanged.
- RAM contents are not reset. Benches must write a location before reading it.
- MMIO offsets (`addr[7:0]`):
  - 0x00 write (word or byte): push `writedata[7:0]` into the FIFO.
  - 0x00 read: `{30'b0, full, empty}`.
  - 0x04 read: the cycle counter. Writes are ignored.
  - 0x08 read: `{16'b0, dropcnt}`. Any write clears `dropcnt` to 0.
  - All other offsets read 0; writes are ignored.
- FIFO behaviour:
  - Circular buffer with read pointer, write pointer and an occupancy count.
  - `dbg_valid = (count!=0)`; `dbg_data` = the entry at the read pointer.
  - A pop occurs when `dbg_valid & dbg_ready`. The read pointer advances and wraps modulo `FIFO_DEPTH`.
  - A push when not full stores the byte and advances the write pointer, wrapping.
  - A push when full with no pop in the same cycle is dropped. `dropcnt` increments, saturating at 0xFFFF.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This applies even when full, so no drop occurs.
  - Pop when empty cannot occur, because `dbg_valid` is low.
- Cycle counter: 32-bit. Increments every cycle from reset and wraps 0xFFFFFFFF→0.

## Timing
- Load latency is 0 cycles: `readdata` is valid in the same cycle as `addr`.
- Stores, FIFO pushes, pops and counter updates commit at the rising edge.
- A read issued in the same cycle as a write to the same RAM word returns the old data. The new data is visible from the next cycle.
- An MMIO status read in a cycle returns state before that cycle's edge.
- A pushed byte appears on `dbg_valid`/`dbg_data` the cycle after the push edge.
- `dbg_data` changes only at an edge.
- Reset (asynchronous, may be asserted mid-operation):
  - Immediately forces FIFO count and pointers, `dropcnt` and the cycle counter to 0.
  - Therefore `dbg_valid`=0 immediately.
  - RAM keeps its contents.
- Reset values of outputs:
  - `dbg_valid`=0.
  - `dbg_data` = don't-care (FIFO storage is not reset).
  - `readdata` follows `addr`; MMIO 0x00 reads 0x1 (empty).
- First edge after reset deassertion: the cycle counter reads 0 before the edge and 1 after it.

## Test plan
- Word/byte stores:
  - Stimulus: sw 0x11223344 @0x10; then sb `writedata`=0xAA @0x12; then load @0x10.
  - Required response: the load returns 0x11AA3344; a load @0x10+4·`DEPTH_WORDS` returns the same value (alias).
- Read-during-write:
  - Stimulus: sw 0xDEADBEEF @0x20 with load @0x20 in the same cycle.
  - Required response: the old value is returned; the next cycle returns 0xDEADBEEF.
- FIFO fill/drain with `dbg_ready`=0:
  - Stimulus: push 0x41..0x45.
  - Required response: status reads 0x2 (full) after 4 pushes; `dropcnt`=1.
  - Then raise `dbg_ready`: the bytes drain as 0x41,0x42,0x43,0x44 on consecutive cycles, then `dbg_valid`=0 and status reads 0x1.
- Simultaneous push+pop when full:
  - Stimulus: FIFO full, `dbg_ready`=1, push 0x99 in the same cycle.
  - Required response: no drop (`dropcnt` unchanged); 0x99 emerges fourth after the popped head.
- Counters:
  - Stimulus: read 0x04 N cycles after reset; write to 0x08.
  - Required response: 0x04 returns N. After the write, 0x08 reads 0.
  - Stimulus: force 65540 drops.
  - Required response: 0x08 reads 0xFFFF.
- Mid-operation reset:
  - Stimulus: assert `reset` between edges with the FIFO holding 3 entries.
  - Required response: `dbg_valid` falls without an edge; status reads 0x1; RAM word @0x10 is retained.
